// File: rtl/pipeline_memd_stage7.sv
// ----------------------------------------------------------------------------
// pipeline_memd_stage7
//
// Second memory stage (MEMD) of the pipeline. It finishes loads that were
// issued in MEMP: it picks the raw read data (system bus or DRAM), aligns it
// to the access offset and sign/zero extends it to 64 bits. DRAM reads may
// take several cycles. While they are outstanding the stage asks the hazard
// unit to freeze upstream (stall_req) and sends bubbles to WB. Reads that
// never return are aborted after TIMEOUT cycles with mem_err_MEMD set.
//
// Handshake: dram_valid is a one-sided strobe. Data on dram_dout is
// consumed in any cycle where dram_valid=1 while a DRAM load is in IDLE
// or WAIT. There is no ready back to the DRAM, so data that arrives while
// the external stall is asserted is parked in a hold buffer. It is
// delivered once the stall is released, so read data is never dropped.
//
// Ports
//   clk, reset            clock and asynchronous active-high reset
//   stall                 external stall from the hazard unit (freezes outputs)
//   *_MEMP                instruction fields registered by the MEMP stage
//   sys_bus_dout          bus read data for the access currently in MEMD
//   dram_dout, dram_valid DRAM read data and its valid strobe
//   stall_req             combinational request to freeze upstream stages
//   *_MEMD                registered results handed to WB
//   fsm_state             current controller state (0 IDLE, 1 WAIT, 2 HOLD)
// ----------------------------------------------------------------------------
module pipeline_memd_stage7 #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        is_dram_MEMP,
  input  logic [63:0] pc_MEMP,
  input  logic [1:0]  rf_wr_sel_MEMP,
  input  logic        rf_wr_en_MEMP,
  input  logic [63:0] alu_result_MEMP,
  input  logic [4:0]  rd_MEMP,
  input  logic [2:0]  mem_rd_ctrl_MEMP,
  input  logic [63:0] sys_bus_dout,
  input  logic [63:0] dram_dout,
  input  logic        dram_valid,
  output logic        stall_req,
  output logic [63:0] pc_MEMD,
  output logic [1:0]  rf_wr_sel_MEMD,
  output logic        rf_wr_en_MEMD,
  output logic [63:0] alu_result_MEMD,
  output logic [4:0]  rd_MEMD,
  output logic [63:0] dm_dout_MEMD,
  output logic        mem_err_MEMD,
  output logic [1:0]  fsm_state
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  // Load type encoding of mem_rd_ctrl_MEMP
  localparam logic [2:0] RD_NONE = 3'd0;
  localparam logic [2:0] RD_LB   = 3'd1;
  localparam logic [2:0] RD_LBU  = 3'd2;
  localparam logic [2:0] RD_LH   = 3'd3;
  localparam logic [2:0] RD_LHU  = 3'd4;
  localparam logic [2:0] RD_LW   = 3'd5;
  localparam logic [2:0] RD_LWU  = 3'd6;
  localparam logic [2:0] RD_LD   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [63:0]     hold_data, hold_data_nx;
  logic            hold_err, hold_err_nx;
  logic            stall_req_int;
  logic            res_err;
  logic [63:0]     raw_sel;
  logic [63:0]     ext_data;
  logic            dram_load;
  logic            timeout_hit;

  // Align the addressed item to bit 0 and extend it. LD is always 8-byte
  // aligned, so it bypasses the shifter.
  function automatic logic [63:0] load_extend(input logic [63:0] raw,
                                              input logic [2:0]  offset,
                                              input logic [2:0]  ctrl);
    logic [63:0] sh;
    logic [63:0] r;
    sh = raw >> {offset, 3'b000};
    case (ctrl)
      RD_LB:   r = {{56{sh[7]}},  sh[7:0]};
      RD_LBU:  r = {56'd0,        sh[7:0]};
      RD_LH:   r = {{48{sh[15]}}, sh[15:0]};
      RD_LHU:  r = {48'd0,        sh[15:0]};
      RD_LW:   r = {{32{sh[31]}}, sh[31:0]};
      RD_LWU:  r = {32'd0,        sh[31:0]};
      RD_LD:   r = raw;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Only DRAM reads can wait. Bus loads, stores and ALU ops finish at once.
  assign dram_load   = is_dram_MEMP && (mem_rd_ctrl_MEMP != RD_NONE);
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  // --------------------------------------------------------------------------
  // Controller: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hold_data <= 64'd0;
      hold_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      hold_data <= hold_data_nx;
      hold_err  <= hold_err_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Controller: next state, stall request and result source
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    hold_data_nx  = hold_data;
    hold_err_nx   = hold_err;
    stall_req_int = 1'b0;
    res_err       = 1'b0;
    raw_sel       = is_dram_MEMP ? dram_dout : sys_bus_dout;

    case (state)
      S_IDLE: begin
        if (dram_load) begin
          if (!dram_valid) begin
            stall_req_int = 1'b1;
            cnt_nx        = '0;
            state_nx      = S_WAIT;
          end else if (stall) begin
            // Data is here but WB cannot take it: park it.
            hold_data_nx = dram_dout;
            hold_err_nx  = 1'b0;
            state_nx     = S_HOLD;
          end
        end
      end

      S_WAIT: begin
        if (dram_valid) begin
          if (stall) begin
            hold_data_nx = dram_dout;
            hold_err_nx  = 1'b0;
            state_nx     = S_HOLD;
          end else begin
            state_nx = S_IDLE;
          end
        end else if (timeout_hit) begin
          // Abort: the instruction retires with zero data and the error flag.
          res_err = 1'b1;
          if (stall) begin
            hold_data_nx = 64'd0;
            hold_err_nx  = 1'b1;
            state_nx     = S_HOLD;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          stall_req_int = 1'b1;
          cnt_nx        = cnt + CW'(1);
        end
      end

      S_HOLD: begin
        // The DRAM strobe is ignored. The parked data is the result.
        raw_sel = hold_data;
        res_err = hold_err;
        if (!stall) begin
          state_nx = S_IDLE;
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase

    ext_data = res_err ? 64'd0
                       : load_extend(raw_sel, alu_result_MEMP[2:0], mem_rd_ctrl_MEMP);
  end

  assign stall_req = stall_req_int && !reset;
  assign fsm_state = state;

  // --------------------------------------------------------------------------
  // MEMD output registers. The external stall wins over bubble insertion.
  // A bubble clears only the fields that could cause a side effect in WB.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_MEMD         <= 64'd0;
      rf_wr_sel_MEMD  <= 2'd0;
      rf_wr_en_MEMD   <= 1'b0;
      alu_result_MEMD <= 64'd0;
      rd_MEMD         <= 5'd0;
      dm_dout_MEMD    <= 64'd0;
      mem_err_MEMD    <= 1'b0;
    end else if (!stall) begin
      if (stall_req_int) begin
        rf_wr_en_MEMD <= 1'b0;
        rd_MEMD       <= 5'd0;
        mem_err_MEMD  <= 1'b0;
      end else begin
        pc_MEMD         <= pc_MEMP;
        rf_wr_sel_MEMD  <= rf_wr_sel_MEMP;
        rf_wr_en_MEMD   <= rf_wr_en_MEMP;
        alu_result_MEMD <= alu_result_MEMP;
        rd_MEMD         <= rd_MEMP;
        dm_dout_MEMD    <= ext_data;
        mem_err_MEMD    <= res_err;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_memd_stage7.sv
// ----------------------------------------------------------------------------
// tb_pipeline_memd_stage7
//
// Bench for the MEMD load stage. The reference model works at transaction
// level. For each instruction it computes the extended load value from
// arithmetic on the raw word and the number of stall cycles
// (min(delay, TIMEOUT) for a DRAM load, zero otherwise). It then checks
// bubbles, held outputs and the final retired result cycle by cycle.
// ----------------------------------------------------------------------------
module tb_pipeline_memd_stage7;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        is_dram_MEMP;
  logic [63:0] pc_MEMP;
  logic [1:0]  rf_wr_sel_MEMP;
  logic        rf_wr_en_MEMP;
  logic [63:0] alu_result_MEMP;
  logic [4:0]  rd_MEMP;
  logic [2:0]  mem_rd_ctrl_MEMP;
  logic [63:0] sys_bus_dout;
  logic [63:0] dram_dout;
  logic        dram_valid;
  logic        stall_req;
  logic [63:0] pc_MEMD;
  logic [1:0]  rf_wr_sel_MEMD;
  logic        rf_wr_en_MEMD;
  logic [63:0] alu_result_MEMD;
  logic [4:0]  rd_MEMD;
  logic [63:0] dm_dout_MEMD;
  logic        mem_err_MEMD;
  logic [1:0]  fsm_state;

  int errors = 0;
  int checks = 0;

  // Expected output record of the MEMD registers
  logic [63:0] e_pc, e_alu, e_dout;
  logic [1:0]  e_sel;
  logic        e_wen, e_err;
  logic [4:0]  e_rd;

  logic [63:0] exp_q[$];

  pipeline_memd_stage7 #(.TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .is_dram_MEMP     (is_dram_MEMP),
    .pc_MEMP          (pc_MEMP),
    .rf_wr_sel_MEMP   (rf_wr_sel_MEMP),
    .rf_wr_en_MEMP    (rf_wr_en_MEMP),
    .alu_result_MEMP  (alu_result_MEMP),
    .rd_MEMP          (rd_MEMP),
    .mem_rd_ctrl_MEMP (mem_rd_ctrl_MEMP),
    .sys_bus_dout     (sys_bus_dout),
    .dram_dout        (dram_dout),
    .dram_valid       (dram_valid),
    .stall_req        (stall_req),
    .pc_MEMD          (pc_MEMD),
    .rf_wr_sel_MEMD   (rf_wr_sel_MEMD),
    .rf_wr_en_MEMD    (rf_wr_en_MEMD),
    .alu_result_MEMD  (alu_result_MEMD),
    .rd_MEMD          (rd_MEMD),
    .dm_dout_MEMD     (dm_dout_MEMD),
    .mem_err_MEMD     (mem_err_MEMD),
    .fsm_state        (fsm_state)
  );

  // --------------------------------------------------------------------------
  // Clock
  // --------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"},   pc_MEMD,                 e_pc);
    chk({tag, ".sel"},  {62'd0, rf_wr_sel_MEMD}, {62'd0, e_sel});
    chk({tag, ".wen"},  {63'd0, rf_wr_en_MEMD},  {63'd0, e_wen});
    chk({tag, ".alu"},  alu_result_MEMD,         e_alu);
    chk({tag, ".rd"},   {59'd0, rd_MEMD},        {59'd0, e_rd});
    chk({tag, ".dout"}, dm_dout_MEMD,            e_dout);
    chk({tag, ".err"},  {63'd0, mem_err_MEMD},   {63'd0, e_err});
  endtask

  // Reference load value: pick the addressed bytes with arithmetic and extend.
  function automatic logic [63:0] model_ext(input logic [2:0] ctrl,
                                            input logic [63:0] addr,
                                            input logic [63:0] raw);
    logic [63:0] v;
    logic [63:0] r;
    int          off;
    off = int'(addr % 8);
    v   = raw / (64'd1 << (8 * off));
    case (ctrl)
      3'd1: begin r = v % 64'h100;       if (r >= 64'h80)       r = r | 64'hFFFF_FFFF_FFFF_FF00; end
      3'd2: r = v % 64'h100;
      3'd3: begin r = v % 64'h1_0000;    if (r >= 64'h8000)     r = r | 64'hFFFF_FFFF_FFFF_0000; end
      3'd4: r = v % 64'h1_0000;
      3'd5: begin r = v % 64'h1_0000_0000; if (r >= 64'h8000_0000) r = r | 64'hFFFF_FFFF_0000_0000; end
      3'd6: r = v % 64'h1_0000_0000;
      3'd7: r = raw;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Driver + per-cycle checks for one instruction.
  //   delay : cycles before dram_valid rises (>= TIMEOUT means never)
  //   hold  : external stall cycles applied starting at the completion cycle
  // --------------------------------------------------------------------------
  task automatic run_instr(input string tag, input logic dram, input logic [2:0] ctrl,
                           input logic [63:0] addr, input logic [63:0] raw,
                           input int delay, input int hold);
    logic        load;
    logic        tmo;
    int          comp;
    logic [63:0] n_pc;
    logic [1:0]  n_sel;
    logic        n_wen;
    logic [4:0]  n_rd;

    load = dram && (ctrl != 3'd0);
    tmo  = load && (delay >= TIMEOUT);
    comp = !load ? 0 : (delay < TIMEOUT ? delay : TIMEOUT);
    exp_q.push_back(tmo ? 64'd0 : model_ext(ctrl, addr, raw));

    n_pc  = {$urandom, $urandom};
    n_sel = 2'($urandom_range(0, 3));
    n_wen = 1'($urandom_range(0, 1));
    n_rd  = 5'($urandom_range(0, 31));

    is_dram_MEMP     = dram;
    mem_rd_ctrl_MEMP = ctrl;
    alu_result_MEMP  = addr;
    pc_MEMP          = n_pc;
    rf_wr_sel_MEMP   = n_sel;
    rf_wr_en_MEMP    = n_wen;
    rd_MEMP          = n_rd;

    for (int c = 0; c <= comp + hold; c++) begin
      stall        = (c >= comp) && (c < comp + hold);
      sys_bus_dout = dram ? {$urandom, $urandom} : raw;
      if (!load) begin
        dram_valid = 1'($urandom_range(0, 1));
        dram_dout  = {$urandom, $urandom};
      end else if (c < comp) begin
        dram_valid = 1'b0;
        dram_dout  = {$urandom, $urandom};
      end else if (c == comp) begin
        dram_valid = !tmo;
        dram_dout  = tmo ? {$urandom, $urandom} : raw;
      end else begin
        dram_valid = 1'($urandom_range(0, 1));
        dram_dout  = {$urandom, $urandom};
      end
      #1;
      chk({tag, ".stall_req"}, {63'd0, stall_req}, {63'd0, (c < comp)});
      @(negedge clk);
      if (c < comp) begin
        e_wen = 1'b0;
        e_rd  = 5'd0;
        e_err = 1'b0;
        chk({tag, ".bubble.wen"},  {63'd0, rf_wr_en_MEMD}, 64'd0);
        chk({tag, ".bubble.rd"},   {59'd0, rd_MEMD},       64'd0);
        chk({tag, ".bubble.err"},  {63'd0, mem_err_MEMD},  64'd0);
        chk({tag, ".bubble.pc"},   pc_MEMD,                e_pc);
        chk({tag, ".bubble.dout"}, dm_dout_MEMD,           e_dout);
      end else if (c < comp + hold) begin
        chk_all({tag, ".held"});
      end else begin
        e_pc   = n_pc;
        e_sel  = n_sel;
        e_wen  = n_wen;
        e_alu  = addr;
        e_rd   = n_rd;
        e_dout = exp_q.pop_front();
        e_err  = tmo;
        chk_all({tag, ".done"});
      end
    end
    stall = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    reset            = 1'b1;
    stall            = 1'b0;
    is_dram_MEMP     = 1'b0;
    pc_MEMP          = 64'd0;
    rf_wr_sel_MEMP   = 2'd0;
    rf_wr_en_MEMP    = 1'b0;
    alu_result_MEMP  = 64'd0;
    rd_MEMP          = 5'd0;
    mem_rd_ctrl_MEMP = 3'd0;
    sys_bus_dout     = 64'd0;
    dram_dout        = 64'd0;
    dram_valid       = 1'b0;
    e_pc = 64'd0; e_alu = 64'd0; e_dout = 64'd0;
    e_sel = 2'd0; e_wen = 1'b0; e_err = 1'b0; e_rd = 5'd0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset.stall_req", {63'd0, stall_req}, 64'd0);
    chk_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Bus LB from byte 3, negative byte
    run_instr("bus_lb", 1'b0, 3'd1, 64'h0000_1003, 64'h0000_0000_80FF_0000, 0, 0);
    // DRAM LWU at offset 4, data after 3 cycles
    run_instr("dram_lwu", 1'b1, 3'd6, 64'h0000_2004, 64'hDEAD_BEEF_0000_0000, 3, 0);
    // DRAM LD that never returns: timeout
    run_instr("dram_tmo", 1'b1, 3'd7, 64'h0000_3000, 64'h1234_5678_9ABC_DEF0, 100, 0);
    // Following instruction clears the error flag
    run_instr("after_tmo", 1'b0, 3'd5, 64'h0000_4000, 64'h0000_0000_8000_0001, 0, 0);
    // DRAM LH arriving under external stall: held, then delivered
    run_instr("dram_lh_hold", 1'b1, 3'd3, 64'h0000_5002, 64'h0000_0000_F00D_0000, 0, 2);
    // DRAM load returning in WAIT while stalled
    run_instr("wait_hold", 1'b1, 3'd2, 64'h0000_6007, 64'h7F00_0000_0000_0000, 2, 3);
    // Timeout while stalled
    run_instr("tmo_hold", 1'b1, 3'd4, 64'h0000_7000, 64'hFFFF_FFFF_FFFF_FFFF, 100, 2);
    // DRAM store passes with no wait
    run_instr("dram_store", 1'b1, 3'd0, 64'h0000_8000, 64'hAAAA_AAAA_AAAA_AAAA, 0, 0);

    // Reset in the middle of a wait
    is_dram_MEMP     = 1'b1;
    mem_rd_ctrl_MEMP = 3'd7;
    alu_result_MEMP  = 64'h0000_9000;
    pc_MEMP          = 64'h0000_0000_0000_ABCD;
    rf_wr_en_MEMP    = 1'b1;
    rd_MEMP          = 5'd9;
    dram_valid       = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    e_pc = 64'd0; e_alu = 64'd0; e_dout = 64'd0;
    e_sel = 2'd0; e_wen = 1'b0; e_err = 1'b0; e_rd = 5'd0;
    chk("midreset.stall_req", {63'd0, stall_req}, 64'd0);
    chk_all("midreset");
    @(negedge clk);
    reset = 1'b0;
    run_instr("post_reset_store", 1'b1, 3'd0, 64'h0000_A000, 64'h5555_5555_5555_5555, 0, 0);

    // Randomized instruction mix
    for (int i = 0; i < 40; i++) begin
      logic        r_dram;
      logic [2:0]  r_ctrl;
      int          r_delay;
      int          r_hold;
      r_dram  = 1'($urandom_range(0, 1));
      r_ctrl  = 3'($urandom_range(0, 7));
      r_delay = ($urandom_range(0, 9) == 0) ? TIMEOUT + $urandom_range(0, 4)
                                            : $urandom_range(0, 5);
      r_hold  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_instr("rand", r_dram, r_ctrl, {$urandom, $urandom}, {$urandom, $urandom},
                r_delay, r_hold);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
